// File: rtl/uart_tx_fifo_drain.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_drain
//   UART transmitter that sits directly behind a byte FIFO. Each byte is popped
//   with a one-cycle active-low read strobe. It is then sent on tx as a frame:
//   one start bit, DATA_BITS data bits (LSB first), an optional parity bit and
//   STOP_BITS stop bits. While en=1 the FIFO is drained back-to-back, with a
//   two-cycle idle gap between frames. That gap is the fetch and load cycles.
//
// Parameters
//   CLK_DIV    clocks per bit (>= 2)
//   DATA_BITS  data bits per frame (5..8); upper FIFO word bits are ignored
//   PARITY     0 = none, 1 = even, 2 = odd
//   STOP_BITS  stop bits per frame (1 or 2)
//
// Ports
//   clk         in   system clock, all state changes on posedge
//   nrst        in   asynchronous active-low reset
//   en          in   1 = allowed to start new frames
//   fifo_empty  in   FIFO empty flag
//   fifo_data   in   FIFO read data, valid the cycle after the read strobe
//   fifo_nrd    out  registered active-low read strobe, one-cycle pulse
//   tx          out  registered serial output, idles high
//   busy        out  high in every state except IDLE
// -----------------------------------------------------------------------------
module uart_tx_fifo_drain #(
  parameter int CLK_DIV   = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       en,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_nrd,
  output logic       tx,
  output logic       busy
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state_reg, state_next;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic [BW-1:0]        bit_reg, bit_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 par_reg, par_next;
  logic                 tx_reg, tx_next;
  logic                 nrd_reg, nrd_next;
  logic                 bit_end;
  logic [DATA_BITS-1:0] load_data;

  // tx_next always holds the level for the state being entered. The tx flop
  // therefore changes on the same edge as the state does, and never glitches.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    par_next   = par_reg;
    tx_next    = tx_reg;
    nrd_next   = 1'b1;
    load_data  = fifo_data[DATA_BITS-1:0];
    bit_end    = (cnt_reg == CNT_LAST);

    case (state_reg)
      S_IDLE: begin
        tx_next = 1'b1;
        if (en && !fifo_empty) begin
          state_next = S_FETCH;
          nrd_next   = 1'b0;
        end
      end

      // The pop is already committed, so fifo_empty is not looked at here.
      S_FETCH: begin
        state_next = S_LOAD;
      end

      S_LOAD: begin
        shift_next = load_data;
        par_next   = (PARITY == 2) ? ~^load_data : ^load_data;
        cnt_next   = '0;
        bit_next   = '0;
        tx_next    = 1'b0;
        state_next = S_START;
      end

      S_START: begin
        cnt_next = cnt_reg + 1'b1;
        if (bit_end) begin
          cnt_next   = '0;
          tx_next    = shift_reg[0];
          state_next = S_DATA;
        end
      end

      S_DATA: begin
        cnt_next = cnt_reg + 1'b1;
        if (bit_end) begin
          cnt_next = '0;
          if (bit_reg == DATA_LAST) begin
            bit_next = '0;
            if (PARITY != 0) begin
              tx_next    = par_reg;
              state_next = S_PARITY;
            end else begin
              tx_next    = 1'b1;
              state_next = S_STOP;
            end
          end else begin
            bit_next   = bit_reg + 1'b1;
            shift_next = {1'b0, shift_reg[DATA_BITS-1:1]};
            tx_next    = shift_next[0];
          end
        end
      end

      S_PARITY: begin
        cnt_next = cnt_reg + 1'b1;
        if (bit_end) begin
          cnt_next   = '0;
          tx_next    = 1'b1;
          state_next = S_STOP;
        end
      end

      // bit_reg is reused to count the stop bits.
      S_STOP: begin
        tx_next  = 1'b1;
        cnt_next = cnt_reg + 1'b1;
        if (bit_end) begin
          cnt_next = '0;
          if (bit_reg == STOP_LAST) begin
            bit_next = '0;
            if (en && !fifo_empty) begin
              state_next = S_FETCH;
              nrd_next   = 1'b0;
            end else begin
              state_next = S_IDLE;
            end
          end else begin
            bit_next = bit_reg + 1'b1;
          end
        end
      end

      default: begin
        tx_next    = 1'b1;
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      par_reg   <= 1'b0;
      tx_reg    <= 1'b1;
      nrd_reg   <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      par_reg   <= par_next;
      tx_reg    <= tx_next;
      nrd_reg   <= nrd_next;
    end
  end

  assign tx       = tx_reg;
  assign fifo_nrd = nrd_reg;
  assign busy     = (state_reg != S_IDLE);

endmodule
